// File: rtl/sub_arb_pkg.sv
// sub_arb_pkg: shared definitions for the shared-subtractor arbiter.
// FSM state encodings, condition-code bit positions and a small helper
// that assembles the {OF,SF,ZF} condition-code vector.
package sub_arb_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;

    function automatic logic [2:0] pack_cc(input logic of, input logic sf, input logic zf);
        logic [2:0] cc;
        cc        = '0;
        cc[CC_OF] = of;
        cc[CC_SF] = sf;
        cc[CC_ZF] = zf;
        return cc;
    endfunction

endpackage

// File: rtl/sub_arbiter_if.sv
// sub_arbiter_if: request/response bundle between requesting units and the
// shared subtractor. The arbiter uses the slave modport, requesters (or a
// testbench) use the master modport.
interface sub_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*64-1:0] req_a;
    logic [NREQ*64-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [63:0]        rsp_diff;
    logic [2:0]         rsp_cc;
    logic [IDW-1:0]     rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_diff, rsp_cc, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_diff, rsp_cc, rsp_id
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority picker. Scans req starting at ptr, wrapping
// modulo NREQ, and returns the first hit as a one-hot grant plus index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            hit
);
    // Walk the requesters in rotated order, first valid one wins
    always_comb begin
        int pos;
        pos   = 0;
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (!hit && req[pos]) begin
                hit        = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDW'(pos);
            end
        end
    end
endmodule

// File: rtl/sub_64bit.sv
// sub_64bit: the single 64-bit subtract datapath, a + (~b + 1).
// Overflow is taken from the carries around the sign bit so that it
// reflects exactly what the adder produced.
module sub_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] diff,
    output logic        overflow
);
    logic [64:0] sum_full;
    logic [63:0] b_inv;
    logic        carry_into_msb;

    assign b_inv          = ~b;
    assign sum_full       = {1'b0, a} + {1'b0, b_inv} + 65'd1;
    assign diff           = sum_full[63:0];
    // Carry into bit 63 recovered from the sum bit and its two operand bits
    assign carry_into_msb = a[63] ^ b_inv[63] ^ sum_full[63];
    assign overflow       = sum_full[64] ^ carry_into_msb;
endmodule

// File: rtl/sub_arbiter.sv
// sub_arbiter: shares one sub_64bit among NREQ requesters with round-robin
// arbitration and a single registered response channel.
// Optional macro SUB_ARB_PRIO_EN: requester 0 gets strict priority and does
// not move the round-robin pointer; ports 1..NREQ-1 rotate among themselves.
module sub_arbiter
    import sub_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    sub_arbiter_if.slave bus
);
    state_t           state;
    state_t           next_state;
    logic [IDW-1:0]   rr_ptr;
    logic [63:0]      a_q;
    logic [63:0]      b_q;
    logic [IDW-1:0]   id_q;

    logic [NREQ-1:0]  pick_req;
    logic [NREQ-1:0]  pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_hit;

    logic [NREQ-1:0]  grant_vec;
    logic [IDW-1:0]   grant_idx;
    logic             grant_hit;
    logic             accept;

    logic [63:0]      sub_diff;
    logic             sub_of;

`ifdef SUB_ARB_PRIO_EN
    // Port 0 is handled outside the rotation, so mask it from the picker
    assign pick_req = bus.req_valid & {{(NREQ-1){1'b1}}, 1'b0};
`else
    assign pick_req = bus.req_valid;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .hit   (pick_hit)
    );

    // Final grant choice: strict port-0 override when enabled, else picker
    always_comb begin
        grant_vec = pick_grant;
        grant_idx = pick_idx;
        grant_hit = pick_hit;
`ifdef SUB_ARB_PRIO_EN
        if (bus.req_valid[0]) begin
            grant_vec    = '0;
            grant_vec[0] = 1'b1;
            grant_idx    = '0;
            grant_hit    = 1'b1;
        end
`endif
    end

    // Next-state logic; grants are only offered while idle and out of reset
    always_comb begin
        next_state    = state;
        bus.req_ready = '0;
        accept        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_hit) begin
                    bus.req_ready = grant_vec & {NREQ{rst_n}};
                    accept        = 1'b1;
                    next_state    = ST_CALC;
                end
            end
            ST_CALC: begin
                next_state = ST_DONE;
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand capture and round-robin pointer advance on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            rr_ptr <= '0;
        end else if (accept) begin
            a_q  <= bus.req_a[int'(grant_idx)*64 +: 64];
            b_q  <= bus.req_b[int'(grant_idx)*64 +: 64];
            id_q <= grant_idx;
`ifdef SUB_ARB_PRIO_EN
            if (grant_idx != '0) begin
                rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            end
`else
            rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
`endif
        end
    end

    sub_64bit u_sub (
        .a        (a_q),
        .b        (b_q),
        .diff     (sub_diff),
        .overflow (sub_of)
    );

    // Response registers: load in CALC, hold through DONE until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_diff  <= '0;
            bus.rsp_cc    <= '0;
            bus.rsp_id    <= '0;
        end else begin
            case (state)
                ST_CALC: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_diff  <= sub_diff;
                    bus.rsp_cc    <= pack_cc(sub_of, sub_diff[63], sub_diff == '0);
                    bus.rsp_id    <= id_q;
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sub_arbiter.sv
// tb_sub_arbiter: directed and randomized checks of sub_arbiter against a
// behavioural model (index-based round-robin, signed-arithmetic flags).
// Honours SUB_ARB_PRIO_EN in the model when defined.
module tb_sub_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sub_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    sub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int model_ptr = 0;
    logic [63:0]     op_a [NREQ];
    logic [63:0]     op_b [NREQ];
    logic [NREQ-1:0] valid_mask = '0;
    logic [63:0]     edge_vals [6];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic driveBus();
        bus.req_valid = valid_mask;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[64*i +: 64] = op_a[i];
            bus.req_b[64*i +: 64] = op_b[i];
        end
    endtask

    // Which port should win given the current valid set and model pointer
    function automatic int modelPick(input logic [NREQ-1:0] m);
`ifdef SUB_ARB_PRIO_EN
        if (m[0]) return 0;
        for (int k = 0; k < NREQ; k++) begin
            if (((model_ptr + k) % NREQ) != 0 && m[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (m[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
`endif
        return -1;
    endfunction

    function automatic void modelAdvance(input int g);
`ifdef SUB_ARB_PRIO_EN
        if (g != 0) model_ptr = (g + 1) % NREQ;
`else
        model_ptr = (g + 1) % NREQ;
`endif
    endfunction

    // Signed-subtraction flags from operand/result signs
    function automatic logic [2:0] modelCc(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] d;
        logic of;
        d  = a - b;
        of = (a[63] != b[63]) && (d[63] != a[63]);
        return {of, d[63], (d == 64'd0)};
    endfunction

    task automatic doReset();
        valid_mask = '0;
        driveBus();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    // One full transaction from grant to response consumption
    task automatic applyStimulus(input int stall, input bit keep);
        int g;
        int cyc;
        logic [63:0] ed;
        logic [2:0]  ec;
        g = modelPick(valid_mask);
        bus.rsp_ready = 1'b0;
        driveBus();
        #1;
        checkOutput("grant", 64'(bus.req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        if (g < 0) return;
        ed = op_a[g] - op_b[g];
        ec = modelCc(op_a[g], op_b[g]);
        modelAdvance(g);
        @(negedge clk);
        checkOutput("ready_calc", 64'(bus.req_ready), 64'd0);
        checkOutput("valid_calc", 64'(bus.rsp_valid), 64'd0);
        if (!keep) begin
            valid_mask[g] = 1'b0;
            driveBus();
        end
        cyc = 0;
        while (!bus.rsp_valid && cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("latency", 64'(cyc), 64'd1);
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        checkOutput("rsp_diff", bus.rsp_diff, ed);
        checkOutput("rsp_cc", 64'(bus.rsp_cc), 64'(ec));
        checkOutput("rsp_id", 64'(bus.rsp_id), 64'(g));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("hold_valid", 64'(bus.rsp_valid), 64'd1);
            checkOutput("hold_diff", bus.rsp_diff, ed);
            checkOutput("hold_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("rsp_cleared", 64'(bus.rsp_valid), 64'd0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        edge_vals[0] = 64'd0;
        edge_vals[1] = 64'd1;
        edge_vals[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        edge_vals[3] = 64'h8000_0000_0000_0000;
        edge_vals[4] = 64'h7FFF_FFFF_FFFF_FFFF;
        edge_vals[5] = 64'd5;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 64'd100 + 64'(i);
            op_b[i] = 64'd1;
        end
        bus.rsp_ready = 1'b0;

        // Reset held with all requests valid
        rst_n = 1'b0;
        valid_mask = 4'hF;
        driveBus();
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_rsp_cc", 64'(bus.rsp_cc), 64'd0);
        checkOutput("rst_rsp_diff", bus.rsp_diff, 64'd0);
        checkOutput("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        rst_n = 1'b1;
        model_ptr = 0;
        applyStimulus(0, 1'b0);

        // Port 2 alone: 10 - 3
        valid_mask = 4'b0100;
        op_a[2] = 64'd10;
        op_b[2] = 64'd3;
        applyStimulus(0, 1'b0);

        // Zero and negative results
        valid_mask = 4'b0010;
        op_a[1] = 64'd5;
        op_b[1] = 64'd5;
        applyStimulus(0, 1'b0);
        valid_mask = 4'b1000;
        op_a[3] = 64'd3;
        op_b[3] = 64'd5;
        applyStimulus(0, 1'b0);

        // Signed overflow: most-negative minus one
        valid_mask = 4'b0001;
        op_a[0] = 64'h8000_0000_0000_0000;
        op_b[0] = 64'd1;
        applyStimulus(0, 1'b0);

        // All ports continuously valid from a fresh pointer
        doReset();
        valid_mask = 4'hF;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = {$urandom, $urandom};
                op_b[i] = {$urandom, $urandom};
            end
            applyStimulus(0, 1'b1);
        end
        valid_mask = '0;
        driveBus();

        // Consumer stalls for five cycles in DONE
        valid_mask = 4'b0010;
        op_a[1] = 64'd77;
        op_b[1] = 64'd99;
        applyStimulus(5, 1'b0);

        // Reset pulse while the operation is in CALC
        valid_mask = 4'b0010;
        driveBus();
        #1;
        checkOutput("pre_abort_grant", 64'(bus.req_ready), 64'(1 << modelPick(valid_mask)));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("abort_req_ready", 64'(bus.req_ready), 64'd0);
        valid_mask = '0;
        driveBus();
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkOutput("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end

        // Randomized traffic with request drops and consumer stalls
        for (int n = 0; n < 40; n++) begin
            valid_mask = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : {$urandom, $urandom};
                op_b[i] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : {$urandom, $urandom};
            end
            applyStimulus($urandom_range(0, 2), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
